// File: rtl/serdes_rx_checker.sv
// Receive-side K28.5 comma/fill pattern checker for the 64-bit SerDes RX datapath.
// Optional macro SERDES_CHK_CODE_ERR_EN: treat 8b/10b code and disparity errors as bad bytes.
module serdes_rx_checker #(
  parameter logic [7:0]  COMMA_BYTE = 8'hBC,
  parameter logic [7:0]  FILL_BYTE  = 8'h4A,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             rx_clk,
  input  logic             rx_rstn_i,
  input  logic             rx_valid_i,
  input  logic [63:0]      rx_data_i,
  input  logic [7:0]       rx_char_is_k_i,
  input  logic [7:0]       rx_not_in_table_i,
  input  logic [7:0]       rx_disp_err_i,
  input  logic             cnt_clr_i,
  output logic             locked_o,
  output logic [2:0]       lane_o,
  output logic             err_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [7:0] LOCK_RUN   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_RUN = 8'(UNLOCK_CNT);

  state_t           state_q, state_d;
  logic [7:0]       run_q, run_d;
  logic [2:0]       lane_q, lane_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [7:0] code_err;
`ifdef SERDES_CHK_CODE_ERR_EN
  assign code_err = rx_not_in_table_i | rx_disp_err_i;
`else
  logic unused_code_err;
  assign code_err        = '0;
  assign unused_code_err = ^{rx_not_in_table_i, rx_disp_err_i};
`endif

  // Per-lane compare against the expected word for the captured lane, plus comma search.
  logic [7:0] bad_lane;
  logic [7:0] cand_hit;
  logic [2:0] cand_lane;

  always_comb begin
    bad_lane  = '0;
    cand_hit  = '0;
    cand_lane = '0;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) == lane_q)
        bad_lane[i] = (rx_data_i[8*i +: 8] != COMMA_BYTE) | ~rx_char_is_k_i[i] | code_err[i];
      else
        bad_lane[i] = (rx_data_i[8*i +: 8] != FILL_BYTE) | rx_char_is_k_i[i] | code_err[i];
      cand_hit[i] = rx_char_is_k_i[i] & (rx_data_i[8*i +: 8] == COMMA_BYTE) & ~code_err[i];
      if (rx_char_is_k_i[i]) cand_lane = 3'(i);
    end
  end

  logic       is_cand;
  logic       any_bad;
  logic [3:0] bad_cnt;
  logic [7:0] run_inc;

  assign is_cand = $onehot(rx_char_is_k_i) & (|cand_hit);
  assign any_bad = |bad_lane;
  assign bad_cnt = 4'($countones(bad_lane));
  assign run_inc = run_q + 8'd1;

  // One extra bit catches the carry so the byte-error add clamps instead of wrapping.
  logic [CNT_W:0]   err_sum;
  logic [CNT_W-1:0] err_cnt_sat;
  logic [CNT_W-1:0] word_cnt_sat;

  assign err_sum      = {1'b0, err_cnt_q} + {{(CNT_W-3){1'b0}}, bad_cnt};
  assign err_cnt_sat  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  assign word_cnt_sat = (&word_cnt_q) ? word_cnt_q : word_cnt_q + CNT_W'(1);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    lane_d     = lane_q;
    err_d      = 1'b0;
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;

    if (rx_valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (is_cand) begin
            lane_d = cand_lane;
            if (LOCK_RUN == 8'd1) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              state_d = VERIFY;
              run_d   = 8'd1;
            end
          end
        end
        VERIFY: begin
          if (any_bad) begin
            err_d   = 1'b1;
            state_d = HUNT;
            run_d   = '0;
          end else if (run_inc == LOCK_RUN) begin
            state_d = LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        LOCKED: begin
          word_cnt_d = word_cnt_sat;
          err_cnt_d  = err_cnt_sat;
          if (any_bad) begin
            err_d = 1'b1;
            if (run_inc == UNLOCK_RUN) begin
              state_d = HUNT;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // A clear discards whatever this cycle would have added.
    if (cnt_clr_i) begin
      word_cnt_d = '0;
      err_cnt_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge rx_clk or negedge rx_rstn_i) begin
    if (!rx_rstn_i) begin
      state_q    <= HUNT;
      run_q      <= '0;
      lane_q     <= '0;
      err_q      <= 1'b0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      lane_q     <= lane_d;
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign locked_o   = (state_q == LOCKED);
  assign lane_o     = lane_q;
  assign err_o      = err_q;
  assign word_cnt_o = word_cnt_q;
  assign err_cnt_o  = err_cnt_q;

endmodule
